vme_cmd_sequencer: RTL

//  Upstream feeder for the simulation VME master. Buffers a queue of VME single-cycle

---
 rtl/vme_cmd_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vme_cmd_sequencer.sv
// Command FIFO and sequencer feeding single-cycle A24/D16 commands to the VME master.
// Issues one command at a time, waits for the done strobe or a timeout, then idles GAP cycles.
module vme_cmd_sequencer #(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int GAP     = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          cmd_push,
   input  logic          cmd_wr,
   input  logic [22:0]   cmd_addr,
   input  logic [15:0]   cmd_data,
   output logic          cmd_full,
   output logic [AW:0]   cmd_count,
   output logic          vme_cmd,
   output logic          vme_wr,
   output logic          vme_rd,
   output logic [22:0]   vme_addr,
   output logic [15:0]   vme_wr_data,
   input  logic          vme_cmd_rd,
   input  logic [15:0]   vme_rd_data,
   output logic          rd_valid,
   output logic [22:0]   rd_addr,
   output logic [15:0]   rd_data,
   output logic          busy,
   output logic          ovf_err,
   output logic          tmo_err,
   input  logic          err_clr
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

   typedef struct packed {
      logic        wr;
      logic [22:0] addr;
      logic [15:0] data;
   } cmd_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   localparam logic [15:0] GAP_LAST = 16'(GAP - 1);

   cmd_t          mem_q [DEPTH];
   cmd_t          head;
   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          wr_q, wr_d, rd_q, rd_d;
   logic [22:0]   addr_q, addr_d, rd_addr_q, rd_addr_d;
   logic [15:0]   wdata_q, wdata_d, rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic          ovf_q, ovf_d, tmo_q, tmo_d;
   logic          push_ok, pop, tmo_set;

   assign cmd_full  = (count_q == FULL_CNT);
   assign push_ok   = cmd_push & ~cmd_full;
   assign head      = mem_q[rd_ptr_q];

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_d    = state_q;
      cnt_d      = cnt_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_addr_d  = rd_addr_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      pop        = 1'b0;
      tmo_set    = 1'b0;
      vme_cmd    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               wr_d    = head.wr;
               rd_d    = ~head.wr;
               addr_d  = head.addr;
               wdata_d = head.data;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            vme_cmd = 1'b1;
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Done is tested before the timeout so a done on the last cycle still counts.
            if (vme_cmd_rd) begin
               if (rd_q) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = vme_rd_data;
                  rd_addr_d  = addr_q;
               end
               cnt_d   = '0;
               state_d = S_GAP;
            end else if (cnt_q == TMO_LAST) begin
               tmo_set = 1'b1;
               cnt_d   = '0;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               wr_d    = 1'b0;
               rd_d    = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      unique case ({push_ok, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase

      // A new error on the same edge as err_clr wins.
      ovf_d = (ovf_q & ~err_clr) | (cmd_push & cmd_full);
      tmo_d = (tmo_q & ~err_clr) | tmo_set;
   end

   // NOTE: the storage array is deliberately not reset; pointers and count alone define valid entries.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= '{wr: cmd_wr, addr: cmd_addr, data: cmd_data};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         cnt_q      <= '0;
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_addr_q  <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q    <= count_d;
         cnt_q      <= cnt_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_addr_q  <= rd_addr_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         ovf_q      <= ovf_d;
         tmo_q      <= tmo_d;
      end
   end

   assign cmd_count   = count_q;
   assign vme_wr      = wr_q;
   assign vme_rd      = rd_q;
   assign vme_addr    = addr_q;
   assign vme_wr_data = wdata_q;
   assign rd_valid    = rd_valid_q;
   assign rd_addr     = rd_addr_q;
   assign rd_data     = rd_data_q;
   assign busy        = (state_q != S_IDLE) || (count_q != '0);
   assign ovf_err     = ovf_q;
   assign tmo_err     = tmo_q;

endmodule
